sram_port_arbiter: RTL and testbench

- Shares one single-port, 1-cycle-latency SRAM between the instruction-fetch requester (IF stage) and the data requester (MEM stage).
- Allows a unified-memory build of the five-stage pipeline.
- Grants at most one request per cycle, pipelines grants back-to-back, and routes each response to its owner one cycle after the grant.
- Starvation guard: a data-favoured stream cannot lock out fetch indefinitely.

---
 rtl/sram_port_arbiter_if.sv | 60 ++++++
 rtl/sram_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if
//   Bundles the fetch requester, data requester and SRAM-side signals of the
//   unified-memory arbiter into one interface.
//
//   Signal groups:
//     inst_*  : fetch request (req/addr) and its response (addr_ok, data_ok, rdata)
//     data_*  : data request (req/wr/wstrb/addr/wdata) and its response
//     sram_*  : single-port SRAM command (en/we/addr/wdata) and read data
//
//   Modports:
//     slave  : the arbiter's view (takes requests, drives the SRAM command)
//     master : the environment's view (requesters plus the SRAM macro)
interface sram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Fetch port
  logic                  inst_req;
  logic [ADDR_WIDTH-1:0] inst_addr;
  logic                  inst_addr_ok;
  logic                  inst_data_ok;
  logic [DATA_WIDTH-1:0] inst_rdata;

  // Data port
  logic                  data_req;
  logic                  data_wr;
  logic [STRB_WIDTH-1:0] data_wstrb;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [DATA_WIDTH-1:0] data_wdata;
  logic                  data_addr_ok;
  logic                  data_data_ok;
  logic [DATA_WIDTH-1:0] data_rdata;

  // SRAM port
  logic                  sram_en;
  logic [STRB_WIDTH-1:0] sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic [DATA_WIDTH-1:0] sram_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one single-port SRAM with a 1-cycle read latency between the
//   instruction-fetch requester and the data requester. At most one request
//   is granted per cycle, grants may issue back-to-back, and each response is
//   routed to its owner exactly one cycle after its grant.
//
//   Contention policy:
//     default build     : data wins ties, but once fetch has lost MAX_WAIT
//                         consecutive cycles it wins the next tie.
//     SRAM_ARB_RR_EN    : strict round-robin; the requester not granted last
//                         wins a tie (first tie after reset goes to data).
//
//   Ports:
//     clk    : clock, all state on the rising edge
//     resetn : asynchronous active-low reset; also blanks grants and SRAM
//              enables combinationally while held
//     bus    : sram_port_arbiter_if.slave carrying both requester ports and
//              the SRAM command/read-data signals
module sram_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  sram_port_arbiter_if.slave    bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  logic                  grant_inst;
  logic                  grant_data;
  logic                  resp_valid;
  owner_e                resp_owner;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_WIDTH-1:0] sel_we;

`ifdef SRAM_ARB_RR_EN
  owner_e last_grant;
`else
  // MAX_WAIT = 0 would give a zero-width counter; keep at least one bit.
  localparam int CNT_WIDTH = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_WAIT);
  logic [CNT_WIDTH-1:0] starve_cnt;
`endif

  // Grant decision. Holding reset suppresses every grant so nothing reaches
  // the SRAM or the response pipeline while the system is being reset.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (resetn) begin
      if (bus.inst_req && bus.data_req) begin
`ifdef SRAM_ARB_RR_EN
        if (last_grant == OWNER_DATA) grant_inst = 1'b1;
        else                          grant_data = 1'b1;
`else
        // With MAX_WAIT = 0 this compare is always true: fetch wins ties.
        if (starve_cnt >= CNT_MAX) grant_inst = 1'b1;
        else                       grant_data = 1'b1;
`endif
      end else begin
        grant_inst = bus.inst_req;
        grant_data = bus.data_req;
      end
    end
  end

  // SRAM command mux. Fetches are always reads; a data write with an empty
  // strobe still occupies the SRAM slot and is acknowledged like any write.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = '0;
    if (grant_data) begin
      sel_addr  = bus.data_addr;
      sel_wdata = bus.data_wdata;
      sel_we    = bus.data_wr ? bus.data_wstrb : '0;
    end else if (grant_inst) begin
      sel_addr  = bus.inst_addr;
    end
  end

  assign bus.inst_addr_ok = grant_inst;
  assign bus.data_addr_ok = grant_data;
  assign bus.sram_en      = grant_inst | grant_data;
  assign bus.sram_we      = sel_we;
  assign bus.sram_addr    = sel_addr;
  assign bus.sram_wdata   = sel_wdata;

  // One-deep response tracker: remembers whether last cycle issued an SRAM
  // access and who owns the data that the SRAM returns this cycle. Reset
  // clears it, so a response in flight at reset is silently dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_valid <= 1'b0;
      resp_owner <= OWNER_INST;
    end else begin
      resp_valid <= grant_inst | grant_data;
      resp_owner <= grant_data ? OWNER_DATA : OWNER_INST;
    end
  end

  assign bus.inst_data_ok = resp_valid && (resp_owner == OWNER_INST);
  assign bus.data_data_ok = resp_valid && (resp_owner == OWNER_DATA);
  assign bus.inst_rdata   = bus.sram_rdata;
  assign bus.data_rdata   = bus.sram_rdata;

`ifdef SRAM_ARB_RR_EN
  // Remember the most recent winner so the other side wins the next tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= OWNER_INST;
    end else if (grant_inst) begin
      last_grant <= OWNER_INST;
    end else if (grant_data) begin
      last_grant <= OWNER_DATA;
    end
  end
`else
  // Counts consecutive cycles a pending fetch has been passed over. It
  // saturates rather than wrapping so a long data burst cannot roll it back
  // below the threshold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (!bus.inst_req || grant_inst) begin
      starve_cnt <= '0;
    end else if (starve_cnt < CNT_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
//   Self-checking bench for sram_port_arbiter. A small word-addressed SRAM
//   model sits on the SRAM side. A reference model tracks which requester
//   should win each cycle (from pending requests and how many consecutive
//   cycles fetch has lost), the expected response one cycle later, and the
//   expected memory contents, then compares against the arbiter's outputs.
module tb_sram_port_arbiter;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 4;

  logic clk;
  logic resetn;

  int checks;
  int errors;

  sram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sram_port_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_WAIT  (MAX_WAIT)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-on contents of the 16-word memory; word 0 holds a known fetch word.
  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'h02800C0C;
    return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  // SRAM model: one access per enabled cycle, read data on the next cycle.
  // It reloads its power-on contents during reset.
  logic [31:0] sram_mem [16];
  logic [3:0]  sram_idx;
  assign sram_idx = bus.sram_addr[5:2];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 16; i++) sram_mem[i] <= init_word(i);
      bus.sram_rdata <= '0;
    end else if (bus.sram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.sram_we[b]) sram_mem[sram_idx][b*8 +: 8] <= bus.sram_wdata[b*8 +: 8];
      bus.sram_rdata <= sram_mem[sram_idx];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [16];
  logic        exp_rv;
  logic        exp_ro;
  logic        exp_rd_chk;
  logic [31:0] exp_rd;
  int          inst_losses;
  logic        last_data;
  logic        gi_last;
  logic        gd_last;

  task automatic reset_model();
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    exp_rv      = 1'b0;
    exp_ro      = 1'b0;
    exp_rd_chk  = 1'b0;
    exp_rd      = '0;
    inst_losses = 0;
    last_data   = 1'b0;
    gi_last     = 1'b0;
    gd_last     = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic ireq, input logic [31:0] iaddr,
                                input logic dreq, input logic dwr, input logic [3:0] dstrb,
                                input logic [31:0] daddr, input logic [31:0] dwdata);
    bus.inst_req   = ireq;
    bus.inst_addr  = iaddr;
    bus.data_req   = dreq;
    bus.data_wr    = dwr;
    bus.data_wstrb = dstrb;
    bus.data_addr  = daddr;
    bus.data_wdata = dwdata;
  endtask

  // Checks one cycle against the model, advances the model, then moves to
  // just after the next rising edge where new inputs may be applied.
  task automatic check_output();
    logic       exp_gi;
    logic       exp_gd;
    logic [3:0] widx;
    #1;
    check("inst_data_ok", 32'(bus.inst_data_ok), 32'(exp_rv & ~exp_ro));
    check("data_data_ok", 32'(bus.data_data_ok), 32'(exp_rv & exp_ro));
    if (exp_rv && exp_rd_chk) begin
      if (exp_ro) check("data_rdata", bus.data_rdata, exp_rd);
      else        check("inst_rdata", bus.inst_rdata, exp_rd);
    end

    exp_gi = 1'b0;
    exp_gd = 1'b0;
    if (bus.inst_req && bus.data_req) begin
`ifdef SRAM_ARB_RR_EN
      if (last_data) exp_gi = 1'b1;
      else           exp_gd = 1'b1;
`else
      if (inst_losses >= MAX_WAIT) exp_gi = 1'b1;
      else                         exp_gd = 1'b1;
`endif
    end else begin
      exp_gi = bus.inst_req;
      exp_gd = bus.data_req;
    end

    check("inst_addr_ok", 32'(bus.inst_addr_ok), 32'(exp_gi));
    check("data_addr_ok", 32'(bus.data_addr_ok), 32'(exp_gd));
    check("sram_en", 32'(bus.sram_en), 32'(exp_gi | exp_gd));
    check("sram_we", 32'(bus.sram_we), (exp_gd && bus.data_wr) ? 32'(bus.data_wstrb) : 32'h0);
    if (exp_gi || exp_gd) begin
      check("sram_addr", bus.sram_addr, exp_gd ? bus.data_addr : bus.inst_addr);
      check("sram_wdata", bus.sram_wdata, exp_gd ? bus.data_wdata : 32'h0);
    end

    widx       = exp_gd ? bus.data_addr[5:2] : bus.inst_addr[5:2];
    exp_rv     = exp_gi | exp_gd;
    exp_ro     = exp_gd;
    exp_rd_chk = exp_gi || (exp_gd && !bus.data_wr);
    exp_rd     = ref_mem[widx];
    if (exp_gd && bus.data_wr)
      for (int b = 0; b < 4; b++)
        if (bus.data_wstrb[b]) ref_mem[widx][b*8 +: 8] = bus.data_wdata[b*8 +: 8];

    if (bus.inst_req && !exp_gi) inst_losses++;
    else                         inst_losses = 0;
    if (exp_gi)      last_data = 1'b0;
    else if (exp_gd) last_data = 1'b1;
    gi_last = exp_gi;
    gd_last = exp_gd;

    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    reset_model();

    // Requests raised while in reset must not reach the SRAM.
    repeat (2) @(posedge clk);
    #1;
    apply_stimulus(1'b1, 32'h40, 1'b1, 1'b1, 4'hF, 32'h44, 32'h1234_5678);
    #1;
    check("rst_inst_addr_ok", 32'(bus.inst_addr_ok), 32'h0);
    check("rst_data_addr_ok", 32'(bus.data_addr_ok), 32'h0);
    check("rst_sram_en", 32'(bus.sram_en), 32'h0);
    check("rst_sram_we", 32'(bus.sram_we), 32'h0);
    check("rst_inst_data_ok", 32'(bus.inst_data_ok), 32'h0);
    check("rst_data_data_ok", 32'(bus.data_data_ok), 32'h0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Lone fetch of the known word at 0x1C000000.
    apply_stimulus(1'b1, 32'h1C00_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check_output();
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("fetch_rdata", bus.inst_rdata, 32'h02800C0C);
    check("fetch_data_ok", 32'(bus.inst_data_ok), 32'h1);
    check_output();

    // Partial write with lower two byte lanes.
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF);
    #1;
    check("wr_sram_we", 32'(bus.sram_we), 32'h3);
    check("wr_sram_wdata", bus.sram_wdata, 32'hDEAD_BEEF);
    check_output();
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("wr_ack", 32'(bus.data_data_ok), 32'h1);
    check_output();

    // Back-to-back fetch then data read, no bubble between responses.
    apply_stimulus(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check_output();
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    check_output();
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("b2b_data_ok", 32'(bus.data_data_ok), 32'h1);
    check_output();

    // Both requesters held: data wins four times, fetch on the fifth, data again.
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(1'b1, 32'h10, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
`ifndef SRAM_ARB_RR_EN
      #1;
      check("starve_pattern", 32'(bus.data_addr_ok), (k == 4) ? 32'h0 : 32'h1);
`endif
      check_output();
    end
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check_output();

    // Reset asserted between a grant and its response drops the response.
    apply_stimulus(1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("mid_grant", 32'(bus.inst_addr_ok), 32'h1);
    @(negedge clk);
    resetn = 1'b0;
    reset_model();
    #1;
    check("mid_rst_sram_en", 32'(bus.sram_en), 32'h0);
    check("mid_rst_addr_ok", 32'(bus.inst_addr_ok), 32'h0);
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_inst_ok", 32'(bus.inst_data_ok), 32'h0);
    check("post_rst_data_ok", 32'(bus.data_data_ok), 32'h0);

    // Randomized traffic; each requester holds its request until granted.
    for (int n = 0; n < 400; n++) begin
      if (!bus.inst_req || gi_last) begin
        bus.inst_req  = ($urandom_range(0, 3) != 0);
        bus.inst_addr = $urandom;
      end
      if (!bus.data_req || gd_last) begin
        bus.data_req   = ($urandom_range(0, 3) != 0);
        bus.data_wr    = 1'($urandom_range(0, 1));
        bus.data_wstrb = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
        bus.data_addr  = $urandom;
        bus.data_wdata = $urandom;
      end
      check_output();
    end
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check_output();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
